// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state encodings and the default
//               operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Operation encoding as presented on the op port.
  // Bit 1 selects divide, bit 0 selects signed.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit_cond_neg.sv
`default_nettype none
// ============================================================================
// Module      : cond_neg
// Description : Combinational conditional two's-complement negate.
//               o_y = i_neg ? -i_a : i_a  (modulo 2^W)
// Ports       : i_a   [W-1:0] value in
//               i_neg         negate when high
//               o_y   [W-1:0] value out
// Revision    : 1.0 - initial release
// ============================================================================
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic         i_neg,
  output logic [W-1:0] o_y
);

  assign o_y = i_neg ? ((~i_a) + W'(1)) : i_a;

endmodule : cond_neg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit holding architectural HI/LO.
//               MULT/MULTU: shift-add, one multiplier bit per cycle.
//               DIV/DIVU  : restoring divide, one quotient bit per cycle.
//               Fixed 33-edge latency from the start edge to done.
// Ports       : clk, rst_n           clock, async active-low reset
//               start, op, opa, opb  issue request and operands
//               wr_hi, wr_lo, wdata  MTHI/MTLO writes (ignored while busy)
//               busy                 high in CALC and FIX
//               done                 one-cycle completion pulse
//               div_zero             divisor was zero (held until next start)
//               hi, lo               HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6            // 2**CNT_W must exceed WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e             r_state;
  op_e                r_op;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_dz_pend;
  logic [WIDTH-1:0]   r_a;         // |opa|: multiplicand
  logic [WIDTH-1:0]   r_b;         // |opb|: divisor
  logic [WIDTH-1:0]   r_opa_raw;   // original dividend for divide-by-zero
  logic [2*WIDTH-1:0] r_acc;       // {upper, lower} working accumulator
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // --------------------------------------------------------------------------
  // Operand absolute values at issue
  // --------------------------------------------------------------------------
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_neg_a = op[0] & opa[WIDTH-1];
  assign w_neg_b = op[0] & opb[WIDTH-1];

  cond_neg #(.W(WIDTH)) u_abs_a (.i_a(opa), .i_neg(w_neg_a), .o_y(w_abs_a));
  cond_neg #(.W(WIDTH)) u_abs_b (.i_a(opb), .i_neg(w_neg_b), .o_y(w_abs_b));

  // --------------------------------------------------------------------------
  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  // The carry out of the add becomes the new MSB.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Divide step: acc = {remainder, dividend/quotient}. Shift the next dividend
  // bit into the remainder, subtract the divisor if it fits, and shift the
  // quotient bit in at the bottom. The remainder is always < divisor, so the
  // restored/subtracted value fits in WIDTH bits.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_dsub;
  logic [WIDTH-1:0]   w_rem_new;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_dsub     = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_rem_new  = w_ge ? w_dsub : w_rem_sh[WIDTH-1:0];
  assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

  // --------------------------------------------------------------------------
  // Result sign correction
  // --------------------------------------------------------------------------
  logic               w_sign_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_sign_diff = r_neg_a ^ r_neg_b;

  cond_neg #(.W(2*WIDTH)) u_fix_prod (
    .i_a   (r_acc),
    .i_neg ((r_op == OP_MULT) & w_sign_diff),
    .o_y   (w_prod)
  );

  cond_neg #(.W(WIDTH)) u_fix_quot (
    .i_a   (r_acc[WIDTH-1:0]),
    .i_neg ((r_op == OP_DIV) & w_sign_diff),
    .o_y   (w_quot)
  );

  // Remainder follows the dividend's sign (truncating division).
  cond_neg #(.W(WIDTH)) u_fix_rem (
    .i_a   (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg ((r_op == OP_DIV) & r_neg_a),
    .o_y   (w_rem)
  );

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MULTU;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_opa_raw <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      // MTHI/MTLO land only while not busy; the FIX edge is always busy, so
      // a result write there can never be overridden by these.
      if (!r_busy && wr_hi) r_hi <= wdata;
      if (!r_busy && wr_lo) r_lo <= wdata;

      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op      <= op_e'(op);
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_dz_pend <= op[1] & (opb == '0);
            r_a       <= w_abs_a;
            r_b       <= w_abs_b;
            r_opa_raw <= opa;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_dz      <= 1'b0;
            r_state   <= S_CALC;
          end else begin
            r_state   <= S_IDLE;
          end
        end

        S_CALC: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (!r_op[1]) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_dz_pend) begin
            r_hi <= r_opa_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_dz    <= r_dz_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done. poke=1 pulses start with other
  // operands mid-CALC; poke=2 pulses wr_lo mid-CALC. quiet stays 1 if busy
  // stayed high and hi/lo stayed unchanged until done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int lat, output bit e0_busy,
                        output bit e0_dz, output bit quiet);
    logic [31:0] h0;
    logic [31:0] l0;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = 32'hDEAD_BEEF; opb = 32'h0BAD_F00D;
    e0_busy = busy; e0_dz = div_zero; h0 = hi; l0 = lo; quiet = 1'b1; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0; wr_lo = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || hi !== h0 || lo !== l0) quiet = 1'b0;
      if (k == 5 && poke == 1) begin start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9; end
      if (k == 5 && poke == 2) begin wr_lo = 1'b1; wdata = 32'h1234; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    #2;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy/done/dz=%b%b%b hi=%h lo=%h, expected all 0", busy, done, div_zero, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat; bit eb; bit ed; bit q;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, eb, ed, q);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    checks++;
    if (eb !== 1'b1 || q !== 1'b1) begin errors++; $display("FAIL multu_busy: e0_busy=%b quiet=%b expected 1 1", eb, q); end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || busy !== 1'b0) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h busy=%b expected fffffffe 00000001 0", hi, lo, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_mult_back_to_back;
    int lat; bit eb; bit ed; bit q;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, lat, eb, ed, q);
    checks++;
    if (lat !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mult_neg: lat=%0d hi=%h lo=%h expected 33 ffffffff ffffffeb", lat, hi, lo);
    end
    // Still in the DONE cycle: the next start lands on E34.
    run_op(2'b00, 32'd6, 32'd7, 0, lat, eb, ed, q);
    checks++;
    if (eb !== 1'b1 || lat !== 33) begin errors++; $display("FAIL b2b_start: e0_busy=%b lat=%0d expected 1 33", eb, lat); end
    checks++;
    if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL b2b_result: hi=%h lo=%h expected 0 2a", hi, lo); end
  endtask

  task automatic test_div;
    int lat; bit eb; bit ed; bit q;
    run_op(2'b10, 32'd100, 32'd7, 0, lat, eb, ed, q);
    checks++;
    if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2 || div_zero !== 1'b0) begin
      errors++; $display("FAIL divu: lat=%0d lo=%h hi=%h dz=%b expected 33 e 2 0", lat, lo, hi, div_zero);
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, lat, eb, ed, q);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: lo=%h hi=%h expected fffffffd ffffffff", lo, hi);
    end
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, eb, ed, q);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_min: lo=%h hi=%h expected 80000000 0", lo, hi);
    end
  endtask

  task automatic test_div_zero;
    int lat; bit eb; bit ed; bit q;
    run_op(2'b10, 32'd5, 32'd0, 0, lat, eb, ed, q);
    checks++;
    if (lat !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'd5 || div_zero !== 1'b1) begin
      errors++; $display("FAIL divu_zero: lat=%0d lo=%h hi=%h dz=%b expected 33 ffffffff 5 1", lat, lo, hi, div_zero);
    end
    run_op(2'b11, 32'hFFFF_FFF8, 32'd0, 0, lat, eb, ed, q);
    checks++;
    if (ed !== 1'b0) begin errors++; $display("FAIL dz_clear: dz after next start=%b expected 0", ed); end
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF8 || div_zero !== 1'b1) begin
      errors++; $display("FAIL div_zero_signed: lo=%h hi=%h dz=%b expected ffffffff fffffff8 1", lo, hi, div_zero);
    end
  endtask

  task automatic test_ignore_while_busy;
    int lat; bit eb; bit ed; bit q;
    run_op(2'b10, 32'd100, 32'd7, 1, lat, eb, ed, q);
    checks++;
    if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL start_ignored: lat=%0d lo=%h hi=%h expected 33 e 2", lat, lo, hi);
    end
    run_op(2'b00, 32'd6, 32'd7, 2, lat, eb, ed, q);
    checks++;
    if (q !== 1'b1 || lo !== 32'd42 || hi !== 32'h0) begin
      errors++; $display("FAIL wr_ignored: quiet=%b lo=%h hi=%h expected 1 2a 0", q, lo, hi);
    end
  endtask

  task automatic test_write_idle;
    int lat;
    @(negedge clk);
    wr_lo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    checks++;
    if (lo !== 32'h1234 || hi !== 32'h0) begin errors++; $display("FAIL mtlo_idle: lo=%h hi=%h expected 1234 0", lo, hi); end
    // MTHI together with start: write lands, op proceeds.
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'hABCD; start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd5;
    @(posedge clk); #1;
    wr_hi = 1'b0; start = 1'b0;
    checks++;
    if (hi !== 32'hABCD || busy !== 1'b1) begin errors++; $display("FAIL mthi_with_start: hi=%h busy=%b expected abcd 1", hi, busy); end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++;
    if (lat !== 33 || lo !== 32'd15 || hi !== 32'h0) begin
      errors++; $display("FAIL op_after_mthi: lat=%0d lo=%h hi=%h expected 33 f 0", lat, lo, hi);
    end
  endtask

  task automatic test_reset_mid;
    int lat; bit eb; bit ed; bit q;
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    wr_hi = 1'b0; start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy/done/dz=%b%b%b hi=%h lo=%h expected all 0", busy, done, div_zero, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'd3, 32'd4, 0, lat, eb, ed, q);
    checks++;
    if (lat !== 33 || lo !== 32'd12 || hi !== 32'h0) begin
      errors++; $display("FAIL after_reset_op: lat=%0d lo=%h hi=%h expected 33 c 0", lat, lo, hi);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_back_to_back();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_write_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit downstream of the register bank.
- Consumes the two read-port operands (rs, rt) when decode issues a MULT/MULTU/DIV/DIVU. It computes over multiple cycles and holds the result in architectural HI/LO registers.
- The controller stalls on busy. MFHI/MFLO read hi/lo directly. MTHI/MTLO write through wr_hi/wr_lo.

Parameters:
- WIDTH, 32, operand width. hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request, sampled on rising edge
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- opa  in  WIDTH  rs operand (multiplicand / dividend)
- opb  in  WIDTH  rt operand (multiplier / divisor)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle completion pulse
- div_zero  out  1  divisor was zero; valid with done
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-operation):
  - state goes to IDLE.
  - hi, lo, busy, done and div_zero all go to 0.
  - The iteration counter clears.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1:
  - Latch op, |opa| and |opb|, and the sign flags. Unsigned ops and non-negative operands pass through unchanged.
  - Set counter to 0 and go to CALC.
  - This edge is E0.
- start while in CALC or FIX is ignored. The controller must hold the request until busy is low.
- CALC performs one iteration per edge:
  - Multiply: shift-add on a 2*WIDTH accumulator, one bit per edge.
  - Divide: restoring divide producing one quotient bit per edge.
  - After WIDTH iterations (edges E1..E32) go to FIX.
- FIX edge (E33):
  - Apply sign correction and write hi/lo. Set done=1 and div_zero if applicable.
  - Go to DONE.
- DONE lasts one cycle:
  - done=1 for that cycle only.
  - Goes to IDLE at E34 unless start=1, in which case it goes straight to CALC.
- busy=1 exactly in CALC and FIX. Latency from start edge to done high is 33 edges, fixed for every op, including divide by zero.
- Multiply result: {hi,lo} = full 2*WIDTH product. Signed MULT negates the product iff the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed DIV truncates toward zero: the quotient is negated iff the signs differ, and the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Wrap, no trap.
- Divide by zero (opb==0, DIV or DIVU):
  - lo = all ones, hi = original opa (unmodified, signed or not).
  - div_zero=1 in the DONE cycle, then cleared when the next op starts.
- MTHI/MTLO:
  - wr_hi/wr_lo load wdata on the edge when busy=0.
  - Ignored when busy=1.
  - If a write coincides with the FIX edge, the FIX result wins.
  - wr_hi together with start in IDLE is legal: the write lands and the op proceeds.
- Operands are captured only at the start edge. Later changes to opa/opb are ignored.
- hi/lo hold their values between operations. Partial results are never visible on hi/lo during CALC.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - state encodings (S_IDLE, S_CALC, S_FIX, S_DONE)
  - WIDTH default
- One sub-module, cond_neg: a combinational WIDTH-parametrised conditional two's-complement negate. It is instantiated for operand absolute value and for result sign fix (product uses 2*WIDTH).

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done high exactly after edge 33; busy high for edges E1..E33 only.
- MULT opa=0xFFFFFFFD (-3), opb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); back-to-back start in the DONE cycle with MULTU 6*7 -> hi=0, lo=42.
- DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1 with done, same 33-edge latency; next op clears div_zero.
- start pulsed mid-CALC with different operands -> ignored, first result unchanged; wr_lo=1, wdata=0x1234 while busy -> ignored; same write while idle -> lo=0x1234.
- rst_n low at E10 of a DIV -> busy, done, hi, lo all 0 immediately (asynchronous); after release, MULTU 3*4 -> lo=12, done after 33 edges.
